pio_edge_service_ctrl: RTL



---
 rtl/pio_svc_pkg.sv | 23 ++
 rtl/pio_evt_fifo.sv | 64 ++++++
 rtl/pio_edge_service_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pio_svc_pkg.sv
// Shared definitions for the pushbutton PIO edge service controller.
// Holds the controller FSM state type and the PIO slave register map.
package pio_svc_pkg;

  typedef enum logic [2:0] {
    StRstWait,
    StInitMask,
    StInitClr,
    StIdle,
    StRdIssue,
    StRdWait,
    StClrWrite
  } pio_svc_state_e;

  // PIO slave register addresses
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  // Width of the optional event timestamp
  localparam int unsigned TsWidth = 16;

endpackage

// File: rtl/pio_evt_fifo.sv
// Synchronous event FIFO with a registered head.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, push_data_i write side; a push while full is only taken if a pop happens too
//   full_o, empty_o    occupancy flags
//   valid_o, data_o    head entry (data forced to zero while empty)
//   ready_i            consumer accepts the head entry
module pio_evt_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  input  logic             ready_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop, push_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign valid_o = !empty_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  assign pop     = valid_o && ready_i;
  assign push_en = push_i && (!full_o || pop);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_en && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push_en && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/pio_edge_service_ctrl.sv
// Avalon-MM master that programs and services a pushbutton PIO slave.
// After reset it writes the irq mask and clears stale edge captures, then on
// each PIO irq it reads the edge-capture register, clears exactly the bits it
// read and queues the (masked) capture as an event for a valid/ready consumer.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   irq                 PIO interrupt
//   m_*                 Avalon-MM master towards the PIO (readdata has 1 cycle latency)
//   evt_valid/evt_data  head of the event FIFO, evt_ready pops it
//   evt_time            RD_WAIT cycle count of the head event (PIO_SVC_TIMESTAMP_EN only)
//   busy                high in every state except IDLE
// Build option: define PIO_SVC_TIMESTAMP_EN to add a 16-bit timestamp per event.
module pio_edge_service_ctrl
  import pio_svc_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  MASK  = '1,
  parameter int unsigned       DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             irq,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
`ifdef PIO_SVC_TIMESTAMP_EN
  output logic [15:0]      evt_time,
`endif
  input  logic             evt_ready,
  output logic             busy
);

`ifdef PIO_SVC_TIMESTAMP_EN
  localparam int unsigned EntryW = WIDTH + TsWidth;
`else
  localparam int unsigned EntryW = WIDTH;
`endif

  pio_svc_state_e   state_q, state_d;
  logic [WIDTH-1:0] ev_q, ev_d;
  logic             fifo_push, fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;

  // Upper readdata bits are beyond the PIO width and intentionally ignored.
  logic unused_rdata;
  assign unused_rdata = ^m_readdata;

  assign ev_d = m_readdata[WIDTH-1:0] & MASK;
  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRstWait;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StRdWait) begin
        ev_q <= ev_d;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fifo_push    = 1'b0;
    m_address    = PIO_ADDR_DATA;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    unique case (state_q)
      StRstWait: state_d = StInitMask;
      StInitMask: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = PIO_ADDR_MASK;
        m_writedata  = 32'(MASK);
        state_d      = StInitClr;
      end
      StInitClr: begin
        // Flush anything captured before we were ready to service it.
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = PIO_ADDR_EDGE;
        m_writedata  = 32'({WIDTH{1'b1}});
        state_d      = StIdle;
      end
      StIdle: begin
        // With the FIFO full the edges stay pending (and coalesce) in the PIO.
        if (irq && !fifo_full) begin
          state_d = StRdIssue;
        end
      end
      StRdIssue: begin
        m_chipselect = 1'b1;
        m_address    = PIO_ADDR_EDGE;
        state_d      = StRdWait;
      end
      StRdWait: state_d = (ev_d == '0) ? StIdle : StClrWrite;
      StClrWrite: begin
        // Clear only what was read so later edges on other bits survive.
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = PIO_ADDR_EDGE;
        m_writedata  = 32'(ev_q);
        fifo_push    = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StRstWait;
    endcase
  end

`ifdef PIO_SVC_TIMESTAMP_EN
  logic [TsWidth-1:0] ts_cnt_q, ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      if (state_q == StRdWait) begin
        ts_q <= ts_cnt_q;
      end
    end
  end

  assign fifo_wdata = {ts_q, ev_q};
  assign evt_time   = fifo_rdata[WIDTH +: TsWidth];
`else
  assign fifo_wdata = ev_q;
`endif

  assign evt_data = fifo_rdata[WIDTH-1:0];

  pio_evt_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .valid_o     (evt_valid),
    .data_o      (fifo_rdata),
    .ready_i     (evt_ready)
  );

  logic unused_empty;
  assign unused_empty = fifo_empty;

endmodule
